// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises and debounces the front-panel inputs, decodes the unit
// switches and sequences the count datapath through an IDLE/RUN/PAUSE FSM and a time-base cascade.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_fast,
    input  logic       ms_sw,
    input  logic       s_sw,
    input  logic       min_sw,
    input  logic       hr_sw,
    output logic       cnt_en,
    output logic [3:0] cnt_step,
    output logic       cnt_clr,
    output logic [3:0] unit_sel,
    output logic [9:0] cnt_limit,
    output logic [1:0] state,
    output logic       sw_err
);
    localparam int BW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t          fsm;
    logic [6:0]      sync_p0;
    logic [6:0]      sync_p1;
    logic [DW-1:0]   db_cnt [3];
    logic [2:0]      db_lvl;
    logic [1:0]      db_lvl_d;
    logic [3:0]      sw_vec;
    logic [3:0]      sw_prev;
    logic            sw_valid;
    logic            sw_change;
    logic            start_ev;
    logic            clear_ev;
    logic            clr_now;
    logic            run_adv;
    logic [BW-1:0]   base_cnt;
    logic [9:0]      ms_cnt;
    logic [5:0]      s_cnt;
    logic [5:0]      min_cnt;
    logic            ms_tick;
    logic            s_tick;
    logic            min_tick;
    logic            hr_tick;
    logic            unit_tick;

    function automatic logic is_onehot(input logic [3:0] v);
        is_onehot = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [9:0] limit_of(input logic [3:0] v);
        case (v)
            4'b0001: limit_of = 10'd1000;
            4'b0010: limit_of = 10'd60;
            4'b0100: limit_of = 10'd60;
            4'b1000: limit_of = 10'd24;
            default: limit_of = 10'd0;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchronisers, bit order {hr,min,s,ms,fast,clear,start}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {hr_sw, min_sw, s_sw, ms_sw, btn_fast, btn_clear, btn_start};
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: the accepted level flips after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
        end else begin
            db_lvl_d <= db_lvl[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign start_ev  = db_lvl[0] & ~db_lvl_d[0];
    assign clear_ev  = db_lvl[1] & ~db_lvl_d[1];
    assign sw_vec    = sync_p1[6:3];
    assign sw_valid  = is_onehot(sw_vec);
    assign sw_change = (sw_vec != sw_prev);
    assign clr_now   = sw_change | clear_ev;
    assign run_adv   = (fsm == RUN) && !clr_now;

    assign ms_tick   = run_adv && (base_cnt == BW'(TICK_DIV - 1));
    assign s_tick    = ms_tick && (ms_cnt == 10'd999);
    assign min_tick  = s_tick && (s_cnt == 6'd59);
    assign hr_tick   = min_tick && (min_cnt == 6'd59);
    assign unit_tick = |(unit_sel & {hr_tick, min_tick, s_tick, ms_tick});

    // Stage p2: FSM, prescaler cascade and registered datapath controls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            sw_prev   <= '0;
            base_cnt  <= '0;
            ms_cnt    <= '0;
            s_cnt     <= '0;
            min_cnt   <= '0;
            cnt_en    <= 1'b0;
            cnt_step  <= '0;
            cnt_clr   <= 1'b0;
            unit_sel  <= '0;
            cnt_limit <= '0;
            sw_err    <= 1'b0;
        end else begin
            sw_prev   <= sw_vec;
            unit_sel  <= sw_valid ? sw_vec : 4'd0;
            cnt_limit <= limit_of(sw_vec);
            sw_err    <= !sw_valid;
            cnt_clr   <= clr_now;
            cnt_en    <= unit_tick;
            if (unit_tick) cnt_step <= db_lvl[2] ? 4'd10 : 4'd1;

            if (clr_now || !sw_valid) begin
                fsm <= IDLE;
            end else if (start_ev) begin
                fsm <= (fsm == RUN) ? PAUSE : RUN;
            end

            // PAUSE falls through both branches, so the cascade keeps its phase
            if (fsm == IDLE || clr_now) begin
                base_cnt <= '0;
                ms_cnt   <= '0;
                s_cnt    <= '0;
                min_cnt  <= '0;
            end else if (run_adv) begin
                base_cnt <= ms_tick ? '0 : base_cnt + BW'(1);
                if (ms_tick)  ms_cnt  <= s_tick   ? 10'd0 : ms_cnt + 10'd1;
                if (s_tick)   s_cnt   <= min_tick ? 6'd0  : s_cnt + 6'd1;
                if (min_tick) min_cnt <= hr_tick  ? 6'd0  : min_cnt + 6'd1;
            end
        end
    end

    assign state = fsm;

endmodule
